// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: command opcodes, send codes,
// receive FSM states and the fixed ALU operand register addresses.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam logic [1:0] SEND_NONE   = 2'b00;
  localparam logic [1:0] SEND_ALU_W1 = 2'b10;
  localparam logic [1:0] SEND_ALU_W2 = 2'b01;
  localparam logic [1:0] SEND_REG    = 2'b11;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    RD_SEND,
    OPA,
    OPB,
    ALU_FUN,
    ALU_WAIT,
    SEND1,
    SEND2
  } rx_state_t;

endpackage

// File: rtl/cmd_receive.sv
// Receive-side command decoder: parses framed UART commands, drives the
// register file, ALU and clock gate, and paces send codes against FIFO full.
module cmd_receive
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    rx_out,
  input  logic                     rx_data_vld,
  input  logic                     reg_rd_data_vld,
  input  logic                     alu_out_vld,
  input  logic                     fifo_full,
  output logic [ADDR_WIDTH-1:0]    reg_addr,
  output logic                     reg_wr_en,
  output logic [DATA_WIDTH-1:0]    reg_wr_data,
  output logic                     reg_rd_en,
  output logic                     alu_en,
  output logic [ALU_FUN_WIDTH-1:0] alu_fun,
  output logic                     clk_gate_en,
  output logic [1:0]               send_ctrl_sig,
  output logic                     cmd_error
);

  rx_state_t state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      reg_addr      <= '0;
      reg_wr_en     <= 1'b0;
      reg_wr_data   <= '0;
      reg_rd_en     <= 1'b0;
      alu_en        <= 1'b0;
      alu_fun       <= '0;
      clk_gate_en   <= 1'b0;
      send_ctrl_sig <= SEND_NONE;
      cmd_error     <= 1'b0;
    end else begin
      reg_wr_en     <= 1'b0;
      reg_rd_en     <= 1'b0;
      alu_en        <= 1'b0;
      cmd_error     <= 1'b0;
      send_ctrl_sig <= SEND_NONE;

      case (state)
        IDLE: begin
          if (rx_data_vld) begin
            if (rx_out == DATA_WIDTH'(CMD_WR))
              state <= WR_ADDR;
            else if (rx_out == DATA_WIDTH'(CMD_RD))
              state <= RD_ADDR;
            else if (rx_out == DATA_WIDTH'(CMD_ALU_OP))
              state <= OPA;
            else if (rx_out == DATA_WIDTH'(CMD_ALU_NOP))
              state <= ALU_FUN;
            else
              cmd_error <= 1'b1;
          end
        end

        WR_ADDR: begin
          if (rx_data_vld) begin
            reg_addr <= rx_out[ADDR_WIDTH-1:0];
            state    <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (rx_data_vld) begin
            reg_wr_data <= rx_out;
            reg_wr_en   <= 1'b1;
            state       <= IDLE;
          end
        end

        RD_ADDR: begin
          if (rx_data_vld) begin
            reg_addr  <= rx_out[ADDR_WIDTH-1:0];
            reg_rd_en <= 1'b1;
            state     <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (reg_rd_data_vld)
            state <= RD_SEND;
        end

        RD_SEND: begin
          if (!fifo_full) begin
            send_ctrl_sig <= SEND_REG;
            state         <= IDLE;
          end
        end

        OPA: begin
          if (rx_data_vld) begin
            reg_addr    <= ADDR_WIDTH'(OPA_ADDR);
            reg_wr_data <= rx_out;
            reg_wr_en   <= 1'b1;
            state       <= OPB;
          end
        end

        OPB: begin
          if (rx_data_vld) begin
            reg_addr    <= ADDR_WIDTH'(OPB_ADDR);
            reg_wr_data <= rx_out;
            reg_wr_en   <= 1'b1;
            state       <= ALU_FUN;
          end
        end

        ALU_FUN: begin
          if (rx_data_vld) begin
            alu_fun     <= rx_out[ALU_FUN_WIDTH-1:0];
            alu_en      <= 1'b1;
            clk_gate_en <= 1'b1;
            state       <= ALU_WAIT;
          end
        end

        ALU_WAIT: begin
          if (alu_out_vld)
            state <= SEND1;
        end

        SEND1: begin
          if (!fifo_full) begin
            send_ctrl_sig <= SEND_ALU_W1;
            state         <= SEND2;
          end
        end

        SEND2: begin
          // The sender counts every nonzero cycle as a word, so wait out the
          // cycle in which word 1 is still on the output.
          if (send_ctrl_sig == SEND_NONE && !fifo_full) begin
            send_ctrl_sig <= SEND_ALU_W2;
            clk_gate_en   <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_receive.sv
// Directed bench for cmd_receive: hand-computed expectations for write, read,
// ALU framing, send-code pacing under FIFO backpressure, errors and reset.
module tb_cmd_receive;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] rx_out;
  logic       rx_data_vld;
  logic       reg_rd_data_vld;
  logic       alu_out_vld;
  logic       fifo_full;
  logic [3:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic       reg_rd_en;
  logic       alu_en;
  logic [3:0] alu_fun;
  logic       clk_gate_en;
  logic [1:0] send_ctrl_sig;
  logic       cmd_error;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  cmd_receive #(
    .DATA_WIDTH   (8),
    .ADDR_WIDTH   (4),
    .ALU_FUN_WIDTH(4)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .rx_out         (rx_out),
    .rx_data_vld    (rx_data_vld),
    .reg_rd_data_vld(reg_rd_data_vld),
    .alu_out_vld    (alu_out_vld),
    .fifo_full      (fifo_full),
    .reg_addr       (reg_addr),
    .reg_wr_en      (reg_wr_en),
    .reg_wr_data    (reg_wr_data),
    .reg_rd_en      (reg_rd_en),
    .alu_en         (alu_en),
    .alu_fun        (alu_fun),
    .clk_gate_en    (clk_gate_en),
    .send_ctrl_sig  (send_ctrl_sig),
    .cmd_error      (cmd_error)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_out      = b;
    rx_data_vld = 1'b1;
    step();
    rx_data_vld = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_addr"},  32'(reg_addr), 0);
    check_eq({tag, "_wren"},  32'(reg_wr_en), 0);
    check_eq({tag, "_wdata"}, 32'(reg_wr_data), 0);
    check_eq({tag, "_rden"},  32'(reg_rd_en), 0);
    check_eq({tag, "_aluen"}, 32'(alu_en), 0);
    check_eq({tag, "_fun"},   32'(alu_fun), 0);
    check_eq({tag, "_gate"},  32'(clk_gate_en), 0);
    check_eq({tag, "_send"},  32'(send_ctrl_sig), 0);
    check_eq({tag, "_err"},   32'(cmd_error), 0);
  endtask

  initial begin
    int unsigned nz;
    RST = 1'b1;
    rx_out = '0; rx_data_vld = 1'b0; reg_rd_data_vld = 1'b0;
    alu_out_vld = 1'b0; fifo_full = 1'b0;
    #12;
    check_all_zero("reset");
    RST = 1'b0;
    step();

    // Register write
    send_byte(8'hAA);
    check_eq("wr_hdr_wren", 32'(reg_wr_en), 0);
    send_byte(8'h05);
    check_eq("wr_addr", 32'(reg_addr), 5);
    check_eq("wr_addr_wren", 32'(reg_wr_en), 0);
    send_byte(8'h3C);
    check_eq("wr_wren", 32'(reg_wr_en), 1);
    check_eq("wr_addr2", 32'(reg_addr), 5);
    check_eq("wr_data", 32'(reg_wr_data), 32'h3C);
    check_eq("wr_send", 32'(send_ctrl_sig), 0);
    step();
    check_eq("wr_wren_pulse", 32'(reg_wr_en), 0);

    // Address truncation: upper nibble of 0x9A ignored
    send_byte(8'hAA);
    send_byte(8'h9A);
    send_byte(8'h77);
    check_eq("trunc_addr", 32'(reg_addr), 32'hA);
    check_eq("trunc_data", 32'(reg_wr_data), 32'h77);

    // Register read with a stray byte ignored in RD_WAIT
    send_byte(8'hBB);
    send_byte(8'h07);
    check_eq("rd_rden", 32'(reg_rd_en), 1);
    check_eq("rd_addr", 32'(reg_addr), 7);
    send_byte(8'h55);
    check_eq("rd_rden_pulse", 32'(reg_rd_en), 0);
    check_eq("rd_wait_noerr", 32'(cmd_error), 0);
    step();
    reg_rd_data_vld = 1'b1;
    step();
    reg_rd_data_vld = 1'b0;
    check_eq("rd_send_lat", 32'(send_ctrl_sig), 0);
    step();
    check_eq("rd_send", 32'(send_ctrl_sig), 32'b11);
    nz = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (send_ctrl_sig != 2'b00) nz++;
    end
    check_eq("rd_send_once", nz, 0);

    // ALU with operands
    send_byte(8'hCC);
    send_byte(8'h12);
    check_eq("opa_wren", 32'(reg_wr_en), 1);
    check_eq("opa_addr", 32'(reg_addr), 0);
    check_eq("opa_data", 32'(reg_wr_data), 32'h12);
    send_byte(8'h34);
    check_eq("opb_wren", 32'(reg_wr_en), 1);
    check_eq("opb_addr", 32'(reg_addr), 1);
    check_eq("opb_data", 32'(reg_wr_data), 32'h34);
    send_byte(8'h02);
    check_eq("alu_en", 32'(alu_en), 1);
    check_eq("alu_fun", 32'(alu_fun), 2);
    check_eq("alu_gate", 32'(clk_gate_en), 1);
    check_eq("alu_wren_clr", 32'(reg_wr_en), 0);
    step();
    check_eq("alu_en_pulse", 32'(alu_en), 0);
    check_eq("alu_gate_hold", 32'(clk_gate_en), 1);
    alu_out_vld = 1'b1;
    step();
    alu_out_vld = 1'b0;
    check_eq("alu_s0", 32'(send_ctrl_sig), 0);
    step();
    check_eq("alu_s1", 32'(send_ctrl_sig), 32'b10);
    step();
    check_eq("alu_s_gap", 32'(send_ctrl_sig), 0);
    check_eq("alu_gate_gap", 32'(clk_gate_en), 1);
    step();
    check_eq("alu_s2", 32'(send_ctrl_sig), 32'b01);
    check_eq("alu_gate_off", 32'(clk_gate_en), 0);
    step();
    check_eq("alu_s_end", 32'(send_ctrl_sig), 0);

    // ALU without operands, FIFO full when the result arrives
    send_byte(8'hDD);
    send_byte(8'h01);
    check_eq("nop_alu_en", 32'(alu_en), 1);
    check_eq("nop_fun", 32'(alu_fun), 1);
    check_eq("nop_wren", 32'(reg_wr_en), 0);
    fifo_full   = 1'b1;
    alu_out_vld = 1'b1;
    step();
    alu_out_vld = 1'b0;
    nz = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (send_ctrl_sig != 2'b00) nz++;
    end
    check_eq("full_hold", nz, 0);
    fifo_full = 1'b0;
    step();
    check_eq("full_s1", 32'(send_ctrl_sig), 32'b10);
    step();
    check_eq("full_gap", 32'(send_ctrl_sig), 0);
    step();
    check_eq("full_s2", 32'(send_ctrl_sig), 32'b01);
    check_eq("full_gate_off", 32'(clk_gate_en), 0);

    // Unknown command, then a normal write
    send_byte(8'h55);
    check_eq("err_pulse", 32'(cmd_error), 1);
    step();
    check_eq("err_clear", 32'(cmd_error), 0);
    send_byte(8'hAA);
    check_eq("err_idle", 32'(cmd_error), 0);
    send_byte(8'h01);
    send_byte(8'hFF);
    check_eq("post_err_wren", 32'(reg_wr_en), 1);
    check_eq("post_err_addr", 32'(reg_addr), 1);
    check_eq("post_err_data", 32'(reg_wr_data), 32'hFF);

    // Asynchronous reset mid-frame
    send_byte(8'hAA);
    send_byte(8'h03);
    check_eq("pre_rst_addr", 32'(reg_addr), 3);
    #2;
    RST = 1'b1;
    #1;
    check_all_zero("async_rst");
    step();
    RST = 1'b0;
    step();
    send_byte(8'hFF);
    check_eq("rst_err", 32'(cmd_error), 1);
    check_eq("rst_no_wr", 32'(reg_wr_en), 0);
    step();
    check_eq("rst_no_wr2", 32'(reg_wr_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cmd_receive.md
Name: cmd_receive

Overview:
- Receive-side command decoder of the system controller.
- Consumes bytes from the UART RX path, parses framed commands (register write, register read, ALU with operands, ALU without operands), and drives the register file, ALU and ALU clock gate.
- Drives the 2-bit send control code into the transmit-side data sender, pacing it against TX FIFO full.

Parameters:
- DATA_WIDTH, 8: width of RX bytes and register data.
- ADDR_WIDTH, 4: register file address width; taken from RX byte bits [ADDR_WIDTH-1:0].
- ALU_FUN_WIDTH, 4: ALU function code width; taken from RX byte bits [ALU_FUN_WIDTH-1:0].

Ports:
- CLK  in  1  system clock (single clock domain).
- RST  in  1  asynchronous, active-high reset.
- rx_out  in  DATA_WIDTH  received byte; valid only while rx_data_vld=1.
- rx_data_vld  in  1  one-cycle pulse per received byte.
- reg_rd_data_vld  in  1  register file read data valid pulse.
- alu_out_vld  in  1  ALU result valid pulse.
- fifo_full  in  1  TX FIFO full; blocks issuing send codes.
- reg_addr  out  ADDR_WIDTH  register file address.
- reg_wr_en  out  1  register write strobe, one cycle.
- reg_wr_data  out  DATA_WIDTH  register write data.
- reg_rd_en  out  1  register read strobe, one cycle.
- alu_en  out  1  ALU start, one cycle.
- alu_fun  out  ALU_FUN_WIDTH  ALU function code.
- clk_gate_en  out  1  ALU clock-gate enable.
- send_ctrl_sig  out  2  send code: 10 = ALU word 1, 01 = ALU word 2, 11 = register data, 00 = none.
- cmd_error  out  1  one-cycle pulse on an unknown command byte.

Behaviour:
- **Outputs and reset:** all outputs are registered. On RST high, asynchronously: every output is 0 and the FSM is in IDLE. Reset mid-frame discards the partial frame.
- **Output latency:** every strobe or code is asserted in the cycle after the enabling condition is sampled.
- **Bytes ignored:** an rx_data_vld byte arriving in RD_WAIT, ALU_WAIT, SEND1, SEND2 or RD_SEND is dropped without error.
- **IDLE:** acts on rx_data_vld:
  - 0xAA → WR_ADDR.
  - 0xBB → RD_ADDR.
  - 0xCC → OPA.
  - 0xDD → ALU_FUN.
  - Any other byte: pulse cmd_error and stay in IDLE.
- **WR_ADDR:** on a byte, latch reg_addr → WR_DATA.
- **WR_DATA:** on a byte, set reg_wr_data=byte and pulse reg_wr_en → IDLE.
- **RD_ADDR:** on a byte, latch reg_addr and pulse reg_rd_en → RD_WAIT.
- **RD_WAIT:** on reg_rd_data_vld → RD_SEND.
- **RD_SEND:** if fifo_full=0, send_ctrl_sig=11 for exactly one cycle → IDLE. Otherwise hold 00 and stay.
- **OPA:** on a byte, write it to address 0 (reg_addr=0, reg_wr_en pulse) → OPB.
- **OPB:** on a byte, write it to address 1 → ALU_FUN.
- **ALU_FUN:** on a byte:
  - latch alu_fun;
  - pulse alu_en;
  - set clk_gate_en=1;
  - → ALU_WAIT.
- **ALU_WAIT:** clk_gate_en stays 1. On alu_out_vld → SEND1.
- **SEND1:** if fifo_full=0, emit 10 for one cycle → SEND2. Otherwise hold 00.
- **SEND2:** if fifo_full=0, emit 01 for one cycle, clear clk_gate_en → IDLE. Otherwise hold 00.
- **Send code pacing:** send_ctrl_sig is never nonzero on two consecutive cycles, because the sender treats every nonzero cycle as a new word. SEND2 therefore re-checks fifo_full no earlier than the cycle after 10.
- **Simultaneous events:**
  - alu_out_vld with fifo_full=1: enter SEND1 and wait there.
  - fifo_full deasserting in the same cycle a state is entered: the code issues next cycle.
- **Address truncation:** reg_addr and alu_fun hold their last values between commands; upper RX bits beyond their widths are ignored.
- **No timeout:** a partial frame waits indefinitely for its remaining bytes.

Decomposition:
- **Shared package (sys_ctrl_pkg):**
  - command opcode constants 0xAA/0xBB/0xCC/0xDD;
  - send code constants SEND_NONE/SEND_ALU_W1/SEND_ALU_W2/SEND_REG;
  - the FSM state enum;
  - operand addresses OPA_ADDR=0 and OPB_ADDR=1.
- **Structure:** a single module with no sub-module. The FSM and output registers are one unit, about 200 lines of RTL.

Test Plan:
- Reset, then bytes AA,05,3C → one-cycle reg_wr_en with reg_addr=5, reg_wr_data=0x3C; no send code.
- Bytes BB,07, then reg_rd_data_vld 3 cycles later, fifo_full=0 → reg_rd_en once with addr 7; send_ctrl_sig=11 for exactly one cycle.
- Bytes CC,12,34,02 → writes 0x12@0 and 0x34@1; alu_en pulse with alu_fun=2; clk_gate_en high. On alu_out_vld: 10 then 01 on non-adjacent cycles, then clk_gate_en=0.
- DD,01 with fifo_full=1 when alu_out_vld arrives, released 5 cycles later → no send code while full; 10 and 01 only after release.
- Byte 0x55 in IDLE → cmd_error one-cycle pulse, state IDLE. Then AA,01,FF executes normally.
- Async RST asserted after AA,03 → all outputs 0 immediately. After release, byte FF gives cmd_error and no register write occurs.
